// File: rtl/dep_scoreboard.sv
// dep_scoreboard: circular-window dependency scoreboard for the instruction buffer.
// Records, at allocation, which older in-flight entries each new instruction
// waits on. Clears those waits as producers complete, publishes a per-entry
// ready vector and retires completed entries in program order.
// Optional feature macro: DEP_WAR_WAW_EN adds WAR/WAW tracking (keeps rs masks).
module dep_scoreboard #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned REGNUM = 16,
  parameter int unsigned NSRC   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alloc_valid,
  output logic                              alloc_ready,
  input  logic                              alloc_rd_we,
  input  logic [$clog2(REGNUM)-1:0]         alloc_rd,
  input  logic [NSRC*$clog2(REGNUM)-1:0]    alloc_rs,
  input  logic [NSRC-1:0]                   alloc_rs_en,
  output logic [$clog2(DEPTH)-1:0]          alloc_idx,
  input  logic                              complete_valid,
  input  logic [$clog2(DEPTH)-1:0]          complete_idx,
  output logic [DEPTH-1:0]                  ready_vec,
  output logic                              retire_valid,
  output logic [$clog2(DEPTH)-1:0]          retire_idx,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              full,
  output logic                              empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned RW = $clog2(REGNUM);
  localparam int unsigned CW = IW + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [REGNUM-1:0] rd_mask_q [DEPTH];
`ifdef DEP_WAR_WAW_EN
  logic [REGNUM-1:0] rs_mask_q [DEPTH];
`endif
  logic [DEPTH-1:0]  wait_q [DEPTH];
  logic [IW-1:0]     head_q;
  logic [IW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic              retire_valid_q;
  logic [IW-1:0]     retire_idx_q;

  logic              accept;
  logic              comp_hit;
  logic              retire_hit;
  logic [REGNUM-1:0] new_rd_mask;
  logic [REGNUM-1:0] new_rs_mask;
  logic [DEPTH-1:0]  new_wait;
  logic              live;
  logic              hazard;

  // Status derived directly from the registered pointer state
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign alloc_ready  = ~full;
  assign alloc_idx    = tail_q;
  assign count        = count_q;
  assign retire_valid = retire_valid_q;
  assign retire_idx   = retire_idx_q;

  assign accept     = alloc_valid & alloc_ready;
  assign comp_hit   = complete_valid & valid_q[complete_idx] & ~done_q[complete_idx];
  assign retire_hit = valid_q[head_q] & done_q[head_q];

  // One-hot destination and OR-of-one-hot source masks for the incoming instruction
  always_comb begin
    new_rd_mask = '0;
    new_rs_mask = '0;
    if (alloc_rd_we) new_rd_mask = REGNUM'(1) << alloc_rd;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (alloc_rs_en[k]) new_rs_mask = new_rs_mask | (REGNUM'(1) << alloc_rs[k*RW +: RW]);
    end
  end

  // Wait row for the incoming instruction; a same-cycle completion wins over the new wait bit
  always_comb begin
    new_wait = '0;
    live     = 1'b0;
    hazard   = 1'b0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      live   = valid_q[j] & ~done_q[j] & (tail_q != IW'(j)) &
               ~(comp_hit & (complete_idx == IW'(j)));
      hazard = |(rd_mask_q[j] & new_rs_mask);
`ifdef DEP_WAR_WAW_EN
      hazard = hazard | (|(rs_mask_q[j] & new_rd_mask)) | (|(rd_mask_q[j] & new_rd_mask));
`endif
      new_wait[j] = live & hazard;
    end
  end

  // Entry is issuable when valid, not done and nothing left to wait on
  always_comb begin
    ready_vec = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_vec[i] = valid_q[i] & ~done_q[i] & ~(|wait_q[i]);
    end
  end

  // Entry state, pointers and retire pulse; completion, retire and allocation touch distinct entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_idx_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mask_q[i] <= '0;
`ifdef DEP_WAR_WAW_EN
        rs_mask_q[i] <= '0;
`endif
        wait_q[i]    <= '0;
      end
    end else begin
      retire_valid_q <= retire_hit;
      if (comp_hit) begin
        done_q[complete_idx] <= 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          wait_q[i][complete_idx] <= 1'b0;
        end
      end
      if (retire_hit) begin
        valid_q[head_q]   <= 1'b0;
        done_q[head_q]    <= 1'b0;
        rd_mask_q[head_q] <= '0;
`ifdef DEP_WAR_WAW_EN
        rs_mask_q[head_q] <= '0;
`endif
        wait_q[head_q]    <= '0;
        retire_idx_q      <= head_q;
        head_q            <= head_q + IW'(1);
      end
      if (accept) begin
        valid_q[tail_q]   <= 1'b1;
        done_q[tail_q]    <= 1'b0;
        rd_mask_q[tail_q] <= new_rd_mask;
`ifdef DEP_WAR_WAW_EN
        rs_mask_q[tail_q] <= new_rs_mask;
`endif
        wait_q[tail_q]    <= new_wait;
        tail_q            <= tail_q + IW'(1);
      end
      if (accept && !retire_hit) count_q <= count_q + CW'(1);
      else if (!accept && retire_hit) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_dep_scoreboard.sv
// Testbench for dep_scoreboard: directed scenarios plus randomized traffic
// checked against a program-order queue model of the scoreboard.
module tb_dep_scoreboard;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned REGNUM = 16;
  localparam int unsigned NSRC   = 2;
  localparam int unsigned IW     = $clog2(DEPTH);
  localparam int unsigned RW     = $clog2(REGNUM);

  logic                 clk;
  logic                 rst;
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic                 alloc_rd_we;
  logic [RW-1:0]        alloc_rd;
  logic [NSRC*RW-1:0]   alloc_rs;
  logic [NSRC-1:0]      alloc_rs_en;
  logic [IW-1:0]        alloc_idx;
  logic                 complete_valid;
  logic [IW-1:0]        complete_idx;
  logic [DEPTH-1:0]     ready_vec;
  logic                 retire_valid;
  logic [IW-1:0]        retire_idx;
  logic [IW:0]          count;
  logic                 full;
  logic                 empty;

  int n_tests = 0;
  int n_fail  = 0;

  dep_scoreboard #(.DEPTH(DEPTH), .REGNUM(REGNUM), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd_we(alloc_rd_we), .alloc_rd(alloc_rd),
    .alloc_rs(alloc_rs), .alloc_rs_en(alloc_rs_en),
    .alloc_idx(alloc_idx),
    .complete_valid(complete_valid), .complete_idx(complete_idx),
    .ready_vec(ready_vec),
    .retire_valid(retire_valid), .retire_idx(retire_idx),
    .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-order queue of in-flight entries with explicit dependency sets
  int  ord[$];
  bit  m_valid [DEPTH];
  bit  m_done  [DEPTH];
  bit  m_we    [DEPTH];
  int  m_rd    [DEPTH];
`ifdef DEP_WAR_WAW_EN
  bit  m_src   [DEPTH][REGNUM];
`endif
  bit  m_dep   [DEPTH][DEPTH];
  int  m_tail;
  bit  m_rv;
  int  m_ridx;

  task automatic model_reset();
    ord.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_we[i] = 0; m_rd[i] = 0;
`ifdef DEP_WAR_WAW_EN
      for (int r = 0; r < REGNUM; r++) m_src[i][r] = 0;
`endif
      for (int k = 0; k < DEPTH; k++) m_dep[i][k] = 0;
    end
    m_tail = 0; m_rv = 0; m_ridx = 0;
  endtask

  task automatic model_update(input bit av, input bit we, input int rd, input int rs0,
                              input int rs1, input bit [1:0] en, input bit cv, input int ci);
    bit comp, ret, acc;
    bit nd [DEPTH];
    comp = cv && m_valid[ci] && !m_done[ci];
    ret  = (ord.size() > 0) && m_done[ord[0]];
    acc  = av && (ord.size() < DEPTH);
    for (int i = 0; i < DEPTH; i++) nd[i] = 0;
    foreach (ord[q]) begin
      int j;
      bit hz;
      j = ord[q];
      if (!m_done[j] && !(comp && j == ci)) begin
        hz = m_we[j] && ((en[0] && rs0 == m_rd[j]) || (en[1] && rs1 == m_rd[j]));
`ifdef DEP_WAR_WAW_EN
        if (we && m_src[j][rd]) hz = 1;
        if (we && m_we[j] && m_rd[j] == rd) hz = 1;
`endif
        nd[j] = hz;
      end
    end
    if (comp) begin
      m_done[ci] = 1;
      for (int i = 0; i < DEPTH; i++) m_dep[i][ci] = 0;
    end
    m_rv = ret;
    if (ret) begin
      int h;
      h = ord.pop_front();
      m_valid[h] = 0; m_done[h] = 0;
      m_ridx = h;
    end
    if (acc) begin
      m_valid[m_tail] = 1; m_done[m_tail] = 0;
      m_we[m_tail] = we; m_rd[m_tail] = rd;
`ifdef DEP_WAR_WAW_EN
      for (int r = 0; r < REGNUM; r++) m_src[m_tail][r] = 0;
      if (en[0]) m_src[m_tail][rs0] = 1;
      if (en[1]) m_src[m_tail][rs1] = 1;
`endif
      for (int k = 0; k < DEPTH; k++) m_dep[m_tail][k] = nd[k];
      ord.push_back(m_tail);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  function automatic logic [DEPTH-1:0] model_ready();
    logic [DEPTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      bit waiting;
      waiting = 0;
      for (int k = 0; k < DEPTH; k++) if (m_dep[i][k]) waiting = 1;
      r[i] = m_valid[i] && !m_done[i] && !waiting;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at the falling edge
  task automatic step(input bit av, input bit we, input int rd, input int rs0, input int rs1,
                      input bit [1:0] en, input bit cv, input int ci);
    alloc_valid    = av;
    alloc_rd_we    = we;
    alloc_rd       = RW'(rd);
    alloc_rs       = {RW'(rs1), RW'(rs0)};
    alloc_rs_en    = en;
    complete_valid = cv;
    complete_idx   = IW'(ci);
    @(posedge clk);
    model_update(av, we, rd, rs0, rs1, en, cv, ci);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic do_reset();
    alloc_valid = 0; alloc_rd_we = 0; alloc_rd = '0; alloc_rs = '0; alloc_rs_en = '0;
    complete_valid = 0; complete_idx = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    step(1, 1, 1, 0, 0, 2'b00, 0, 0);
    step(1, 1, 2, 1, 0, 2'b01, 0, 0);
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL reset_pre_count got %0d exp 2", count); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
    n_tests++; if (ready_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b exp 0000", ready_vec); end
    n_tests++; if (alloc_idx !== 2'd0 || alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc got idx=%0d rdy=%b exp idx=0 rdy=1", alloc_idx, alloc_ready); end
    n_tests++; if (retire_valid !== 1'b0 || retire_idx !== 2'd0) begin n_fail++; $display("FAIL reset_retire got v=%b i=%0d exp 0/0", retire_valid, retire_idx); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_raw();
    do_reset();
    step(1, 1, 3, 0, 0, 2'b00, 0, 0);
    n_tests++; if (ready_vec !== 4'b0001) begin n_fail++; $display("FAIL raw_alloc_a got %b exp 0001", ready_vec); end
    step(1, 0, 0, 3, 4, 2'b11, 0, 0);
    n_tests++; if (ready_vec !== 4'b0001) begin n_fail++; $display("FAIL raw_b_waits got %b exp 0001", ready_vec); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 0);
    n_tests++; if (ready_vec !== 4'b0010 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL raw_b_ready got %b rv=%b exp 0010 rv=0", ready_vec, retire_valid); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 1);
    n_tests++; if (retire_valid !== 1'b1 || retire_idx !== 2'd0 || count !== 3'd1) begin n_fail++; $display("FAIL raw_retire_a got v=%b i=%0d c=%0d exp 1/0/1", retire_valid, retire_idx, count); end
    idle();
    n_tests++; if (retire_valid !== 1'b1 || retire_idx !== 2'd1 || empty !== 1'b1) begin n_fail++; $display("FAIL raw_retire_b got v=%b i=%0d e=%b exp 1/1/1", retire_valid, retire_idx, empty); end
    idle();
    n_tests++; if (retire_valid !== 1'b0) begin n_fail++; $display("FAIL raw_retire_pulse got %b exp 0", retire_valid); end
  endtask

  task automatic test_war_waw();
    logic [DEPTH-1:0] e1, e2;
`ifdef DEP_WAR_WAW_EN
    e1 = 4'b0001; e2 = 4'b0010;
`else
    e1 = 4'b0111; e2 = 4'b0110;
`endif
    do_reset();
    step(1, 0, 0, 5, 0, 2'b01, 0, 0);
    step(1, 1, 5, 0, 0, 2'b00, 0, 0);
    step(1, 1, 5, 0, 0, 2'b00, 0, 0);
    n_tests++; if (ready_vec !== e1) begin n_fail++; $display("FAIL warwaw_alloc got %b exp %b", ready_vec, e1); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 0);
    n_tests++; if (ready_vec !== e2) begin n_fail++; $display("FAIL warwaw_after_a got %b exp %b", ready_vec, e2); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 1);
    n_tests++; if (ready_vec !== 4'b0100 || count !== 3'd2) begin n_fail++; $display("FAIL warwaw_after_b got %b c=%0d exp 0100 c=2", ready_vec, count); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    step(1, 1, 3, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 3, 0, 2'b01, 1, 0);
    n_tests++; if (ready_vec !== 4'b0010 || count !== 3'd2) begin n_fail++; $display("FAIL same_cycle got %b c=%0d exp 0010 c=2", ready_vec, count); end
    idle();
    n_tests++; if (retire_valid !== 1'b1 || retire_idx !== 2'd0 || ready_vec !== 4'b0010) begin n_fail++; $display("FAIL same_cycle_retire got v=%b i=%0d r=%b exp 1/0/0010", retire_valid, retire_idx, ready_vec); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 0, 0, 2'b00, 0, 0);
    n_tests++; if (full !== 1'b1 || alloc_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_flags got f=%b r=%b c=%0d exp 1/0/4", full, alloc_ready, count); end
    n_tests++; if (alloc_idx !== 2'd0 || ready_vec !== 4'b1111) begin n_fail++; $display("FAIL full_state got idx=%0d r=%b exp 0/1111", alloc_idx, ready_vec); end
    step(1, 1, 7, 0, 0, 2'b00, 1, 0);
    n_tests++; if (count !== 3'd4 || ready_vec !== 4'b1110) begin n_fail++; $display("FAIL full_refuse got c=%0d r=%b exp 4/1110", count, ready_vec); end
    step(1, 1, 7, 0, 0, 2'b00, 0, 0);
    n_tests++; if (count !== 3'd3 || alloc_idx !== 2'd0 || retire_valid !== 1'b1) begin n_fail++; $display("FAIL full_retire_refuse got c=%0d idx=%0d rv=%b exp 3/0/1", count, alloc_idx, retire_valid); end
    step(1, 1, 7, 0, 0, 2'b00, 0, 0);
    n_tests++; if (count !== 3'd4 || alloc_idx !== 2'd1 || ready_vec !== 4'b1111) begin n_fail++; $display("FAIL wrap_alloc got c=%0d idx=%0d r=%b exp 4/1/1111", count, alloc_idx, ready_vec); end
  endtask

  task automatic test_bogus_complete();
    do_reset();
    step(1, 1, 3, 0, 0, 2'b00, 0, 0);
    step(1, 1, 4, 0, 0, 2'b00, 0, 0);
    step(1, 0, 0, 3, 4, 2'b11, 0, 0);
    step(0, 0, 0, 0, 0, 2'b00, 1, 3);
    n_tests++; if (ready_vec !== 4'b0011 || count !== 3'd3) begin n_fail++; $display("FAIL bogus_invalid got %b c=%0d exp 0011 c=3", ready_vec, count); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 1);
    step(0, 0, 0, 0, 0, 2'b00, 1, 1);
    n_tests++; if (ready_vec !== 4'b0001 || count !== 3'd3 || retire_valid !== 1'b0) begin n_fail++; $display("FAIL bogus_done got %b c=%0d rv=%b exp 0001/3/0", ready_vec, count, retire_valid); end
    step(0, 0, 0, 0, 0, 2'b00, 1, 0);
    n_tests++; if (ready_vec !== 4'b0100) begin n_fail++; $display("FAIL bogus_recover got %b exp 0100", ready_vec); end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      bit av, cv;
      av = ($urandom_range(0, 9) < 6);
      cv = ($urandom_range(0, 9) < 5);
      step(av, 1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           2'($urandom), cv, $urandom_range(0, DEPTH - 1));
      n_tests++;
      if (ready_vec !== model_ready() || count !== 3'(ord.size()) || alloc_idx !== IW'(m_tail) ||
          full !== (ord.size() == DEPTH) || empty !== (ord.size() == 0) ||
          alloc_ready !== (ord.size() != DEPTH) || retire_valid !== m_rv || retire_idx !== IW'(m_ridx)) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL random_cycle%0d got r=%b c=%0d t=%0d rv=%b ri=%0d exp r=%b c=%0d t=%0d rv=%b ri=%0d",
                   c, ready_vec, count, alloc_idx, retire_valid, retire_idx,
                   model_ready(), ord.size(), m_tail, m_rv, m_ridx);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    alloc_valid = 0; alloc_rd_we = 0; alloc_rd = '0; alloc_rs = '0; alloc_rs_en = '0;
    complete_valid = 0; complete_idx = '0;
    model_reset();
    test_reset();
    test_raw();
    test_war_waw();
    test_same_cycle();
    test_full_wrap();
    test_bogus_complete();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dep_scoreboard.md
# dep_scoreboard

- Parametrised dependency scoreboard for the instruction buffer.
- Tracks up to DEPTH in-flight instructions in a circular window and records, at allocation, which older in-flight entries each new instruction depends on (RAW, plus WAR/WAW when enabled).
- Clears dependencies as producers complete and publishes a per-entry ready vector to the issue logic.
- Retires completed entries in program order.

## Interface
- DEPTH, 32: number of buffer entries; power of two, ≥ 4.
- REGNUM, 16: architectural register count; power of two.
- NSRC, 2: source operands per instruction, 1–3.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- alloc_valid  in  1  allocate a new instruction this cycle.
- alloc_ready  out  1  high when not full; allocation happens only when alloc_valid & alloc_ready.
- alloc_rd_we  in  1  instruction writes a destination register.
- alloc_rd  in  $clog2(REGNUM)  destination register.
- alloc_rs  in  NSRC*$clog2(REGNUM)  source registers; operand k is in slice k.
- alloc_rs_en  in  NSRC  per-operand enable; a disabled operand (e.g. immediate) creates no dependency.
- alloc_idx  out  $clog2(DEPTH)  entry index the next allocation receives (the tail pointer).
- complete_valid  in  1  an entry finished execution.
- complete_idx  in  $clog2(DEPTH)  index of the finished entry.
- ready_vec  out  DEPTH  bit i = entry i is valid, not done, and has no outstanding dependency.
- retire_valid  out  1  pulse: the head entry retired this cycle.
- retire_idx  out  $clog2(DEPTH)  index of the retired entry.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation
- **Per-entry state:** valid, done, rd one-hot mask (REGNUM bits, zero if !alloc_rd_we), rs mask (OR of one-hot enabled sources), wait row (DEPTH bits).
- **Allocation:** on accept, entry tail is loaded with valid=1, done=0 and the masks. Then tail = tail+1 mod DEPTH and count++.
- **Wait row:** for each j ≠ tail where entry j is valid & !done, bit j is set when any of the following holds:
  - RAW: rd_mask[j] & new rs mask ≠ 0;
  - WAR: rs_mask[j] bit of new rd (only when WAR/WAW is enabled);
  - WAW: rd_mask[j] bit of new rd (only when WAR/WAW is enabled).
- **Completion:** when complete_valid hits an entry that is valid & !done, that entry gets done=1 and column complete_idx is cleared in every wait row. A completion to an invalid or already-done entry is ignored entirely.
- **Retire:** when the head entry is valid & done, it is cleared (valid=0, masks=0). Then head = head+1 mod DEPTH, count--, and retire_valid=1 with retire_idx=old head. At most one retire per cycle.
- **Alloc and complete in the same cycle, complete_idx = j:** the new wait row excludes bit j (completion wins).
- **Alloc and retire in the same cycle:** both are applied and count is unchanged.
- **Full:** alloc_ready is derived from the registered count. An alloc is refused while full even if a retire occurs that cycle.
- **Wrap-around:** head and tail wrap modulo DEPTH. Entry age is carried only by the wait rows; no age compare is required.
- **State machine:** none beyond the head/tail/count pointer state.

## Timing
- **Reset values:** every valid, done, mask and wait bit = 0; head = tail = 0; count = 0; alloc_ready = 1; alloc_idx = 0; full = 0; empty = 1; ready_vec = 0; retire_valid = 0; retire_idx = 0.
- **Reset mid-operation:** all in-flight entries are discarded immediately and asynchronously.
- **Combinational outputs:** alloc_idx, alloc_ready, full, empty and count are combinational from registered state.
- **Registered outputs:** retire_valid and retire_idx are registered.
- **Allocation latency:** an entry allocated at edge N appears in ready_vec after edge N (if its wait row is zero).
- **Completion latency:** complete at edge N sets done, so the entry leaves ready_vec after N. Dependents whose last wait bit was j become ready after N.
- **Retire latency:** earliest retire of an entry is edge N+1 after its completion edge N; retire_valid is high during the cycle following that edge.
- **Throughput:** 1 alloc, 1 complete and 1 retire per cycle.

## Configuration
- `DEP_WAR_WAW_EN`:
  - Defined: wait rows include WAR and WAW terms as above.
  - Undefined: only RAW is tracked, the rs_mask storage is removed, and WAR/WAW hazards are the responsibility of downstream renaming.

## Test plan
- **Reset:** assert rst with entries occupied -> count=0, empty=1, ready_vec=0, alloc_idx=0 immediately.
- **RAW:** alloc A (rd=r3), then B (rs=r3,r4) -> ready_vec = 0b01. Complete A -> B ready the next cycle; A then B retire on consecutive cycles.
- **WAR/WAW:** alloc A (rs=r5), then B (rd=r5). With DEP_WAR_WAW_EN defined, B waits until A completes; with it undefined, B is ready one cycle after allocation.
- **Same-cycle alloc/complete:** alloc B (rs=r3) in the same cycle A (rd=r3) completes -> B's wait row is 0 and B is ready next cycle.
- **Full/wrap:** fill DEPTH=4 -> full=1 and alloc_ready=0; a further alloc is ignored. Complete and retire entry 0 -> the next alloc gets alloc_idx=0.
- **Bogus completion:** complete an invalid index or an already-done entry -> no state change.
